// File: rtl/bus_arbit_if.sv
// -----------------------------------------------------------------------------
// bus_arbit_if
//
// Purpose:
//   Bundles every signal that passes through the two-master bus arbiter: the
//   request, write-enable, address and write-data lines of both masters, the two
//   grant lines, and the shared slave-side bus that feeds the address decoder.
//
// Modports:
//   master : the view held by the two masters (host and accelerator/DMA). They
//            drive M0_* / M1_* and observe the grants and the shared bus.
//   slave  : the view held by the arbiter, which is the slave of both masters.
//            It consumes M0_* / M1_* and drives the grants and S_*.
//
// Signals:
//   M0_req, M0_wr, M0_address, M0_dout : master 0 (host, default owner)
//   M1_req, M1_wr, M1_address, M1_dout : master 1 (accelerator / DMA)
//   M0_grant, M1_grant                 : exactly one is high at all times
//   S_address, S_wr, S_din             : shared bus towards the decoder/slaves
// -----------------------------------------------------------------------------
interface bus_arbit_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);

    logic                  M0_req;
    logic                  M0_wr;
    logic [ADDR_WIDTH-1:0] M0_address;
    logic [DATA_WIDTH-1:0] M0_dout;

    logic                  M1_req;
    logic                  M1_wr;
    logic [ADDR_WIDTH-1:0] M1_address;
    logic [DATA_WIDTH-1:0] M1_dout;

    logic                  M0_grant;
    logic                  M1_grant;

    logic [ADDR_WIDTH-1:0] S_address;
    logic                  S_wr;
    logic [DATA_WIDTH-1:0] S_din;

    modport master (
        output M0_req, M0_wr, M0_address, M0_dout,
        output M1_req, M1_wr, M1_address, M1_dout,
        input  M0_grant, M1_grant,
        input  S_address, S_wr, S_din
    );

    modport slave (
        input  M0_req, M0_wr, M0_address, M0_dout,
        input  M1_req, M1_wr, M1_address, M1_dout,
        output M0_grant, M1_grant,
        output S_address, S_wr, S_din
    );

endinterface : bus_arbit_if

// File: rtl/bus_arbit.sv
// -----------------------------------------------------------------------------
// bus_arbit
//
// Purpose:
//   Two-master bus arbiter and master-side multiplexer, placed directly upstream
//   of the bus address decoder. Master 0 (host) is the default owner and keeps
//   the bus parked when nobody requests it. Master 1 (accelerator/DMA) gets the
//   bus when it asks and master 0 is idle. Under contention a fairness counter
//   hands the bus over after MAX_HOLD consecutive contended cycles, so neither
//   master can starve the other.
//
// Parameters:
//   ADDR_WIDTH : master and bus address width
//   DATA_WIDTH : write-data width
//   MAX_HOLD   : consecutive contended cycles one master keeps the grant (1..255)
//
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high reset
//   bus   : bus_arbit_if.slave -- master request/write/address/data inputs,
//           grant outputs, and the shared S_address / S_wr / S_din bus
//
// Timing:
//   Requests sampled at edge N change the grant right after edge N (one cycle,
//   no dead cycle between owners). Grants decode straight from the state
//   register. The bus mux is combinational from the registered owner and the
//   owner's live request, so a granted master's beat appears in the same cycle.
// -----------------------------------------------------------------------------
module bus_arbit #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_HOLD   = 8
) (
    input  logic        clk,
    input  logic        reset,
    bus_arbit_if.slave  bus
);

    typedef enum logic {
        M0_GRANT = 1'b0,
        M1_GRANT = 1'b1
    } state_e;

    // Last hold_cnt value an owner may reach under contention; reaching it
    // forces the hand-off on that edge, so the owner holds exactly MAX_HOLD.
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_e     state_q, state_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;

    logic       contended;
    logic       hold_expired;

    assign contended    = bus.M0_req & bus.M1_req;
    assign hold_expired = contended && (hold_cnt_q == HOLD_LAST);

    // -------------------------------------------------------------------------
    // State and fairness counter registers
    // -------------------------------------------------------------------------
    // NOTE: registers are updated with non-blocking assignments so every flop
    // samples the pre-edge values; blocking here would create order-dependent
    // simulation that no longer matches the synthesised hardware.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= M0_GRANT;
            hold_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and fairness counter logic
    // -------------------------------------------------------------------------
    // NOTE: every variable written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = 8'd0;

        unique case (state_q)
            M0_GRANT: begin
                // Hand over either because the host went idle while the
                // accelerator waits, or because the host used up its share.
                if ((!bus.M0_req && bus.M1_req) || hold_expired) begin
                    state_d = M1_GRANT;
                end
            end
            M1_GRANT: begin
                // The accelerator never parks the bus: as soon as it stops
                // requesting, ownership returns to the host.
                if (!bus.M1_req || hold_expired) begin
                    state_d = M0_GRANT;
                end
            end
            default: begin
                state_d = M0_GRANT;
            end
        endcase

        // The counter only measures an unbroken contended run of the current
        // owner; any hand-off or any cycle without contention restarts it.
        if ((state_d == state_q) && contended) begin
            hold_cnt_d = hold_cnt_q + 8'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Grant decode (registered state only, glitch-free)
    // -------------------------------------------------------------------------
    assign bus.M0_grant = (state_q == M0_GRANT);
    assign bus.M1_grant = (state_q == M1_GRANT);

    // -------------------------------------------------------------------------
    // Master-side bus multiplexer
    // -------------------------------------------------------------------------
    // Only the owner can reach the bus. An idle owner drives the all-ones
    // address, which the decoder maps to no slave, with a read and zero data.
    always_comb begin
        bus.S_address = '1;
        bus.S_wr      = 1'b0;
        bus.S_din     = '0;

        if ((state_q == M0_GRANT) && bus.M0_req) begin
            bus.S_address = bus.M0_address;
            bus.S_wr      = bus.M0_wr;
            bus.S_din     = bus.M0_dout;
        end else if ((state_q == M1_GRANT) && bus.M1_req) begin
            bus.S_address = bus.M1_address;
            bus.S_wr      = bus.M1_wr;
            bus.S_din     = bus.M1_dout;
        end
    end

    // -------------------------------------------------------------------------
    // Structural properties
    // -------------------------------------------------------------------------
    // Exactly one master owns the bus at every edge.
    a_grant_onehot: assert property (
        @(posedge clk) disable iff (reset)
        $onehot({bus.M0_grant, bus.M1_grant})
    );

    // The fairness counter can never run past the hand-off point.
    a_hold_bound: assert property (
        @(posedge clk) disable iff (reset)
        hold_cnt_q <= HOLD_LAST
    );

endmodule : bus_arbit

// File: tb/tb_bus_arbit.sv
// -----------------------------------------------------------------------------
// tb_bus_arbit
//
// Self-checking bench for bus_arbit. Each cycle the bench drives both masters
// on the falling edge, a small behavioural model predicts grants, shared bus
// and fairness count, the prediction is pushed to a scoreboard queue, and it
// is popped and compared against the DUT shortly afterwards (well away from
// the rising edge). A second instance with MAX_HOLD=1 covers the
// alternate-every-cycle boundary.
// -----------------------------------------------------------------------------
module tb_bus_arbit;

    localparam int AW       = 8;
    localparam int DW       = 32;
    localparam int MAX_HOLD = 8;

    typedef struct {
        string      tag;
        logic       g0;
        logic       g1;
        logic [7:0] addr;
        logic       wr;
        logic [31:0] din;
        logic [7:0] hold;
    } exp_t;

    logic clk;
    logic reset;

    int   n_checks;
    int   n_errors;
    exp_t sb_q[$];

    // Reference model state: current owner (0/1) and contended-run length.
    int   m_owner;
    int   m_hold;

    bus_arbit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_i ();
    bus_arbit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1_i ();

    bus_arbit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_i)
    );

    bus_arbit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_HOLD(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One bus cycle: drive at negedge, predict, compare, advance the model.
    task automatic cycle(input string tag, input logic rst,
                         input logic r0, input logic w0, input logic [7:0] a0, input logic [31:0] d0,
                         input logic r1, input logic w1, input logic [7:0] a1, input logic [31:0] d1);
        exp_t e;
        exp_t got;
        logic own_req;
        logic sw;
        @(negedge clk);
        reset             = rst;
        bus_i.M0_req      = r0;
        bus_i.M0_wr       = w0;
        bus_i.M0_address  = a0;
        bus_i.M0_dout     = d0;
        bus_i.M1_req      = r1;
        bus_i.M1_wr       = w1;
        bus_i.M1_address  = a1;
        bus_i.M1_dout     = d1;

        own_req = (m_owner == 1) ? r1 : r0;
        e.tag  = tag;
        e.g0   = (m_owner == 0);
        e.g1   = (m_owner == 1);
        e.hold = 8'(m_hold);
        if (!own_req) begin
            e.addr = 8'hFF;
            e.wr   = 1'b0;
            e.din  = 32'h0;
        end else if (m_owner == 0) begin
            e.addr = a0;
            e.wr   = w0;
            e.din  = d0;
        end else begin
            e.addr = a1;
            e.wr   = w1;
            e.din  = d1;
        end
        sb_q.push_back(e);

        #1;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            got = sb_q.pop_front();
            check({got.tag, "_g0"},   64'(bus_i.M0_grant),  64'(got.g0));
            check({got.tag, "_g1"},   64'(bus_i.M1_grant),  64'(got.g1));
            check({got.tag, "_addr"}, 64'(bus_i.S_address), 64'(got.addr));
            check({got.tag, "_wr"},   64'(bus_i.S_wr),      64'(got.wr));
            check({got.tag, "_din"},  64'(bus_i.S_din),     64'(got.din));
            check({got.tag, "_hold"}, 64'(dut.hold_cnt_q),  64'(got.hold));
        end

        // Model update for the coming rising edge.
        if (m_owner == 0) sw = (!r0 && r1);
        else              sw = !r1;
        if (r0 && r1 && (m_hold == MAX_HOLD - 1)) sw = 1'b1;

        if (rst) begin
            m_owner = 0;
            m_hold  = 0;
        end else if (sw) begin
            m_owner = 1 - m_owner;
            m_hold  = 0;
        end else if (r0 && r1) begin
            m_hold = m_hold + 1;
        end else begin
            m_hold = 0;
        end
    endtask

    initial begin
        int         run_len;
        logic       prev_g0;
        logic [7:0] ra;
        logic [31:0] rd;

        n_checks = 0;
        n_errors = 0;
        m_owner  = 0;
        m_hold   = 0;

        reset             = 1'b1;
        bus_i.M0_req      = 1'b0;
        bus_i.M0_wr       = 1'b0;
        bus_i.M0_address  = '0;
        bus_i.M0_dout     = '0;
        bus_i.M1_req      = 1'b0;
        bus_i.M1_wr       = 1'b0;
        bus_i.M1_address  = '0;
        bus_i.M1_dout     = '0;

        bus1_i.M0_req     = 1'b0;
        bus1_i.M0_wr      = 1'b1;
        bus1_i.M0_address = 8'h10;
        bus1_i.M0_dout    = 32'h0000_1010;
        bus1_i.M1_req     = 1'b0;
        bus1_i.M1_wr      = 1'b0;
        bus1_i.M1_address = 8'h20;
        bus1_i.M1_dout    = 32'h0000_2020;

        repeat (2) @(posedge clk);

        // Reset state with both masters idle.
        cycle("rst", 1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0);
        cycle("idle", 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0);

        // Host write, no contention: bus follows M0 in the same cycle.
        for (int i = 0; i < 20; i++) begin
            cycle("m0_wr", 1'b0, 1'b1, 1'b1, 8'h24, 32'h0000_00AA, 1'b0, 1'b0, 8'h00, 32'h0);
        end

        // Host idle, accelerator reads 8'h41, then drops its request.
        for (int i = 0; i < 3; i++) begin
            cycle("m1_rd", 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 8'h41, 32'h0000_1111);
        end
        cycle("m1_drop", 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 8'h41, 32'h0000_1111);
        cycle("back_m0", 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0);

        // Continuous contention: ownership runs must each be MAX_HOLD long.
        run_len = 0;
        prev_g0 = 1'b1;
        for (int i = 0; i < 45; i++) begin
            cycle("contend", 1'b0, 1'b1, 1'b1, 8'h30, 32'h3030_0000 + 32'(i),
                  1'b1, 1'b0, 8'h50, 32'h5050_0000 + 32'(i));
            if (bus_i.M0_grant !== prev_g0) begin
                check("run_len", 64'(run_len), 64'(MAX_HOLD));
                run_len = 1;
                prev_g0 = bus_i.M0_grant;
            end else begin
                run_len++;
            end
        end

        // M1 now owns the bus with hold_cnt=5: reset mid-transfer.
        cycle("rst_mid", 1'b1, 1'b1, 1'b1, 8'h30, 32'h3030_FFFF, 1'b1, 1'b0, 8'h50, 32'h5050_FFFF);
        for (int i = 0; i < 12; i++) begin
            cycle("post_rst", 1'b0, 1'b1, 1'b1, 8'h31, 32'h3131_0000 + 32'(i),
                  1'b1, 1'b1, 8'h51, 32'h5151_0000 + 32'(i));
        end

        // M1 owns and writes; host toggles its lines without requesting.
        for (int i = 0; i < 10; i++) begin
            ra = 8'($urandom);
            rd = $urandom;
            cycle("m1_iso", 1'b0, 1'b0, i[0], ra, rd, 1'b1, 1'b1, 8'h5C, 32'hDEAD_BEEF);
        end

        // Return to idle so the main instance parks on M0.
        cycle("park", 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0);

        // MAX_HOLD=1 instance: owner alternates every contended cycle.
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            bus1_i.M0_req = 1'b1;
            bus1_i.M1_req = 1'b1;
            #1;
            check("mh1_g0",   64'(bus1_i.M0_grant),  64'(k % 2 == 0));
            check("mh1_g1",   64'(bus1_i.M1_grant),  64'(k % 2 == 1));
            check("mh1_addr", 64'(bus1_i.S_address), (k % 2 == 0) ? 64'h10 : 64'h20);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_bus_arbit
